// File: rtl/dmg_video_pkg.sv
// dmg_video_pkg: shared constants, types and helpers for the DMG video path
// (PPU LCD stream consumers, frame-buffer writer, scan-out).
//   H_PIXELS / V_LINES   visible geometry of the LCD stream
//   BYTES_PER_LINE       packed bytes per line (4 pixels per byte)
//   BANK_BYTES           bytes per frame-buffer bank
//   lcd_shade_t          2-bit pixel shade
//   fb_state_t           frame-buffer writer FSM states
package dmg_video_pkg;

  localparam int H_PIXELS       = 160;
  localparam int V_LINES        = 144;
  localparam int BYTES_PER_LINE = H_PIXELS / 4;
  localparam int BANK_BYTES     = BYTES_PER_LINE * V_LINES;

  typedef logic [1:0] lcd_shade_t;

  typedef enum logic [1:0] {WAIT_VS, ACTIVE, FULL} fb_state_t;

  // Left-justify a partial byte holding cnt pixels (oldest pixel in the
  // high bits of the shift register window), zero-padding the low bits.
  function automatic logic [7:0] pad_byte(input logic [5:0] sr, input logic [1:0] cnt);
    case (cnt)
      2'd1:    return {sr[1:0], 6'b0};
      2'd2:    return {sr[3:0], 4'b0};
      2'd3:    return {sr[5:0], 2'b0};
      default: return 8'h00;
    endcase
  endfunction

  // Byte offset inside a bank: y*40 + x/4 without a multiplier.
  // Largest value is 143*40+39 = 5759, well inside 13 bits.
  function automatic logic [12:0] fb_offset(input logic [7:0] y, input logic [7:0] x);
    return ({5'b0, y} << 5) + ({5'b0, y} << 3) + {7'b0, x[7:2]};
  endfunction

endpackage

// File: rtl/fb_pixel_packer.sv
// fb_pixel_packer: packs 2-bit shades four per byte, first pixel in [7:6].
//   clk, rst        clock / synchronous active-low reset
//   line_start      a new line begins this cycle; any partial byte is flushed
//   pix_en          accept pix_color (pixel 0 of the new line if line_start)
//   pix_color       shade of the accepted pixel
//   byte_valid      one-cycle strobe, registered, one cycle after the event
//   byte_data       completed or zero-padded byte
module fb_pixel_packer
  import dmg_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       pix_en,
  input  lcd_shade_t pix_color,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  // Only three pixels are ever held; the fourth goes straight to byte_data.
  logic [5:0] sr;
  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr         <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (line_start) begin
        // A full byte always leaves cnt at 0, so a flush never overlaps a pack.
        if (cnt != 2'd0) begin
          byte_valid <= 1'b1;
          byte_data  <= pad_byte(sr, cnt);
        end
        sr  <= pix_en ? {4'b0, pix_color} : 6'b0;
        cnt <= pix_en ? 2'd1 : 2'd0;
      end else if (pix_en) begin
        sr  <= {sr[3:0], pix_color};
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          byte_valid <= 1'b1;
          byte_data  <= {sr, pix_color};
        end
      end
    end
  end

endmodule

// File: rtl/lcd_fb_writer.sv
// lcd_fb_writer: captures the PPU LCD stream into a double-banked frame buffer.
// Pixels are packed four per byte and written at {bank, y*40 + x/4}; a frame
// that ends cleanly after V_LINES full lines swaps the display bank.
//   clk, rst                       clock / synchronous active-low reset
//   lcd_vsync/hsync/pixel/color    LCD stream from the PPU (same clock)
//   fb_we, fb_addr, fb_wdata       frame-buffer byte write port
//   disp_bank                      bank holding the last complete frame
//   frame_done                     pulse when disp_bank flips
//   frame_err                      pulse when a frame is abandoned
//   stat_frames/stat_errs/stat_last_x   only with LCD_FB_STATS_EN defined:
//                                  saturating frame/error counters and the
//                                  pixel count of the latest bad line
module lcd_fb_writer #(
  parameter int H_PIXELS = dmg_video_pkg::H_PIXELS,
  parameter int V_LINES  = dmg_video_pkg::V_LINES,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_vsync,
  input  logic              lcd_hsync,
  input  logic              lcd_pixel,
  input  logic [1:0]        lcd_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              disp_bank,
  output logic              frame_done,
`ifdef LCD_FB_STATS_EN
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_errs,
  output logic [7:0]        stat_last_x,
`endif
  output logic              frame_err
);
  import dmg_video_pkg::*;

  localparam logic [7:0] H_X    = 8'(H_PIXELS);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  fb_state_t   state;
  logic [7:0]  x, y;
  logic        wbank, frame_bad;
  logic        line_start, to_full_h, pix_en, overflow, short_line, wr_sched;
  logic        done_ev, err_ev;
  logic [12:0] off;

  always_comb begin
    line_start = 1'b0;
    case (state)
      ACTIVE:  line_start = lcd_vsync | lcd_hsync;
      default: line_start = lcd_vsync;
    endcase
    // hsync closing the last visible line: the pixel riding on it belongs to
    // a line that will never be stored.
    to_full_h  = (state == ACTIVE) && !lcd_vsync && lcd_hsync && (x != 8'd0) && (y == Y_LAST);
    pix_en     = line_start ? (lcd_pixel && !to_full_h)
                            : ((state == ACTIVE) && lcd_pixel && (x < H_X));
    overflow   = (state == ACTIVE) && !line_start && lcd_pixel && (x >= H_X);
    // Any partially filled line is bad, even one ending on a byte boundary.
    short_line = (state == ACTIVE) && line_start && (x != 8'd0) && (x < H_X);
    // Address is captured in the same cycle the packer decides to emit.
    wr_sched   = (state == ACTIVE) &&
                 ((line_start && (x[1:0] != 2'd0)) ||
                  (!line_start && pix_en && (x[1:0] == 2'd3)));
    done_ev    = lcd_vsync && (state == FULL) && !frame_bad;
    err_ev     = lcd_vsync && ((state == ACTIVE) || ((state == FULL) && frame_bad));
    off        = fb_offset(y, x);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= WAIT_VS;
      x          <= '0;
      y          <= '0;
      wbank      <= 1'b1;
      frame_bad  <= 1'b0;
      disp_bank  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      fb_addr    <= '0;
    end else begin
      frame_done <= done_ev;
      frame_err  <= err_ev;
      if (wr_sched) fb_addr <= {wbank, (ADDR_W-1)'(off)};
      if (short_line || overflow) frame_bad <= 1'b1;
      if (done_ev) begin
        disp_bank <= wbank;
        wbank     <= ~wbank;
      end
      if (lcd_vsync) begin
        state     <= ACTIVE;
        x         <= {7'b0, pix_en};
        y         <= '0;
        frame_bad <= 1'b0;
      end else if (state == ACTIVE) begin
        if (lcd_hsync) begin
          x <= {7'b0, pix_en};
          // hsync with x=0 only marks a blank line.
          if (x != 8'd0) begin
            y <= y + 8'd1;
            if (y == Y_LAST) state <= FULL;
          end
        end else if (pix_en) begin
          x <= x + 8'd1;
          if ((x == H_X - 8'd1) && (y == Y_LAST)) begin
            state <= FULL;
            y     <= y + 8'd1;
          end
        end
      end
    end
  end

`ifdef LCD_FB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_frames <= '0;
      stat_errs   <= '0;
      stat_last_x <= '0;
    end else begin
      if (done_ev && (stat_frames != 16'hFFFF)) stat_frames <= stat_frames + 16'd1;
      if (err_ev && (stat_errs != 16'hFFFF))    stat_errs   <= stat_errs + 16'd1;
      if (short_line || overflow)               stat_last_x <= x;
    end
  end
`endif

  fb_pixel_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .line_start(line_start),
    .pix_en    (pix_en),
    .pix_color (lcd_color),
    .byte_valid(fb_we),
    .byte_data (fb_wdata)
  );

endmodule

// File: tb/tb_lcd_fb_writer.sv
// tb_lcd_fb_writer: directed + randomized frames against a line-level model of
// the frame buffer (expected byte list per frame, bank/pulse bookkeeping).
module tb_lcd_fb_writer;
  localparam int HP = 160, VL = 144, AW = 14;

  logic          clk = 1'b0, rst = 1'b0;
  logic          lcd_vsync = 1'b0, lcd_hsync = 1'b0, lcd_pixel = 1'b0;
  logic [1:0]    lcd_color = 2'b00;
  logic          fb_we, disp_bank, frame_done, frame_err;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_wdata;
`ifdef LCD_FB_STATS_EN
  logic [15:0]   stat_frames, stat_errs;
  logic [7:0]    stat_last_x;
`endif

  int errs = 0, checks = 0;
  logic [21:0] obs[$];
  logic [21:0] expq[$];
  int n_done = 0, n_err = 0;
  int m_y = 0, m_done = 0, m_err = 0;
  bit m_bad = 0, m_wbank = 1, m_disp = 0, m_active = 0, gaps = 0;

  lcd_fb_writer dut (
    .clk(clk), .rst(rst),
    .lcd_vsync(lcd_vsync), .lcd_hsync(lcd_hsync), .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .disp_bank(disp_bank), .frame_done(frame_done),
`ifdef LCD_FB_STATS_EN
    .stat_frames(stat_frames), .stat_errs(stat_errs), .stat_last_x(stat_last_x),
`endif
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (fb_we) obs.push_back({fb_addr, fb_wdata});
    if (frame_done) n_done++;
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick(input bit v, input bit h, input bit p, input logic [1:0] c);
    lcd_vsync = v; lcd_hsync = h; lcd_pixel = p;
    lcd_color = p ? c : 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    lcd_vsync = 1'b0; lcd_hsync = 1'b0; lcd_pixel = 1'b0;
  endtask

  // Expected writes for one line: ceil(min(n,160)/4) bytes at y*40+k,
  // partial last byte zero-padded. Lines past the last visible one vanish.
  task automatic model_line(input logic [1:0] px[$]);
    int n, acc;
    logic [7:0] b;
    n = px.size();
    if (n == 0 || m_y >= VL) return;
    acc = (n > HP) ? HP : n;
    for (int k = 0; k * 4 < acc; k++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < acc) b[7 - 2 * j -: 2] = px[4 * k + j];
      expq.push_back({m_wbank, 13'(m_y * 40 + k), b});
    end
    // The final line may run long: its extra pixels arrive after the frame is full.
    if ((m_y < VL - 1) ? (n != HP) : (n < HP)) m_bad = 1;
    m_y++;
  endtask

  // mode 0: shades 0,1,2,3 cycling; 1: random; 2: all 3; 3: first 2 then random
  task automatic send_line(input int n, input int mode, input bit pix_on_h);
    logic [1:0] px[$];
    int i0;
    for (int i = 0; i < n; i++)
      px.push_back(mode == 0 ? 2'(i % 4) : mode == 2 ? 2'd3 :
                   (mode == 3 && i == 0) ? 2'd2 : 2'($urandom_range(0, 3)));
    if (pix_on_h && n > 0) begin tick(0, 1, 1, px[0]); i0 = 1; end
    else begin tick(0, 1, 0, 2'd0); i0 = 0; end
    for (int i = i0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick(0, 0, 0, 2'd0);
      tick(0, 0, 1, px[i]);
    end
    model_line(px);
  endtask

  task automatic vsync_edge(input bit with_h);
    tick(1, with_h, 0, 2'd0);
    if (m_active) begin
      if (m_y == VL && !m_bad) begin m_done++; m_disp = m_wbank; m_wbank = ~m_wbank; end
      else m_err++;
    end
    m_active = 1; m_y = 0; m_bad = 0;
    repeat (3) tick(0, 0, 0, 2'd0);
  endtask

  task automatic check_frame(input string tag);
    int nf = 0;
    chk({tag, " write count"}, obs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      assert (obs[i] === expq[i]) else begin
        errs++;
        if (nf < 4) $error("FAIL %s write %0d: observed addr %0h data %0h expected addr %0h data %0h",
                           tag, i, obs[i][21:8], obs[i][7:0], expq[i][21:8], expq[i][7:0]);
        nf++;
      end
    end
    chk({tag, " frame_done count"}, n_done, m_done);
    chk({tag, " frame_err count"}, n_err, m_err);
    chk({tag, " disp_bank"}, disp_bank, m_disp);
    obs.delete();
    expq.delete();
  endtask

  function automatic int cnt_match(input logic [21:0] mask, input logic [21:0] val);
    int c = 0;
    foreach (obs[i]) if ((obs[i] & mask) == val) c++;
    return c;
  endfunction

  initial begin
    int c;
    repeat (3) tick(0, 0, 0, 2'd0);
    chk("reset fb_we", fb_we, 0);
    chk("reset fb_addr", fb_addr, 0);
    chk("reset fb_wdata", fb_wdata, 0);
    chk("reset disp_bank", disp_bank, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset frame_err", frame_err, 0);
    rst = 1'b1;

    // Before the first vsync everything is ignored.
    tick(0, 1, 0, 2'd0);
    repeat (9) tick(0, 0, 1, 2'd3);
    tick(0, 1, 1, 2'd2);
    tick(0, 0, 0, 2'd0);
    chk("wait_vs no writes", obs.size(), 0);
    vsync_edge(0);

    // Frame 1: clean frame, shades cycling.
    for (int l = 0; l < VL; l++) send_line(HP, 0, 0);
    vsync_edge(0);
    chk("f1 bytes 1B", cnt_match(22'h0000FF, 22'h00001B), 5760);
    chk("f1 last addr", obs.size() > 0 ? obs[obs.size() - 1][21:8] : 14'h0, 14'h367F);
    check_frame("f1");

    // Frame 2: clean frame, random shades, lands in bank 0.
    for (int l = 0; l < VL; l++) send_line(HP, 1, 0);
    vsync_edge(0);
    chk("f2 first addr", obs.size() > 0 ? obs[0][21:8] : 14'h3FFF, 14'h0000);
    chk("f2 last addr", obs.size() > 0 ? obs[obs.size() - 1][21:8] : 14'h0, 14'h167F);
    check_frame("f2");

    // Frame 3: line 5 short (158 pixels of shade 3).
    for (int l = 0; l < VL; l++) send_line(l == 5 ? 158 : HP, l == 5 ? 2 : 1, 0);
    vsync_edge(0);
    chk("f3 flush F0 at 239", cnt_match(22'h3FFFFF, {1'b1, 13'd239, 8'hF0}), 1);
    check_frame("f3");

    // Frame 4: overlong line 0, hsync+pixel coincidence, vsync+hsync together.
    send_line(164, 1, 0);
    send_line(8, 1, 0);
    send_line(12, 3, 1);
    vsync_edge(1);
    c = 0;
    foreach (obs[i]) if (obs[i][20:8] < 13'd40) c++;
    chk("f4 line0 writes", c, 40);
    chk("f4 offset40 writes", cnt_match(22'h1FFF00, {1'b0, 13'd40, 8'h00}), 1);
    c = 0;
    foreach (obs[i]) if (obs[i][21:8] == {1'b1, 13'd80}) c = int'(obs[i][7:6]);
    chk("f4 hsync pixel in [7:6]", c, 2);
    check_frame("f4");

    // Random short frames with idle gaps, odd lengths and coincident pixels.
    gaps = 1;
    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++)
        send_line(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 170), 1, 1'($urandom_range(0, 1)));
      vsync_edge(1'($urandom_range(0, 1)));
      check_frame($sformatf("rnd%0d", f));
    end
    gaps = 0;

    // Reset mid-line after two pixels.
    tick(0, 1, 0, 2'd0);
    tick(0, 0, 1, 2'd1);
    tick(0, 0, 1, 2'd2);
    rst = 1'b0;
    tick(0, 0, 0, 2'd0);
    chk("mid reset fb_we", fb_we, 0);
    chk("mid reset fb_addr", fb_addr, 0);
    chk("mid reset fb_wdata", fb_wdata, 0);
    chk("mid reset disp_bank", disp_bank, 0);
    rst = 1'b1;
    m_wbank = 1; m_disp = 0; m_active = 0; m_y = 0; m_bad = 0;
    tick(0, 1, 0, 2'd0);
    repeat (8) tick(0, 0, 1, 2'd3);
    tick(0, 1, 0, 2'd0);
    repeat (2) tick(0, 0, 0, 2'd0);
    chk("post reset no writes", obs.size(), 0);
    vsync_edge(0);
    send_line(8, 1, 0);
    vsync_edge(0);
    check_frame("post reset");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
